// File: rtl/tl_ul_arb2.sv
// Two-master TL-UL arbiter: round-robin A-channel grant into a one-entry stage
// register, combinational D routing by source MSB, per-master outstanding limits.
module tl_ul_arb2 #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [1:0]  m0_a_size,
  input  logic        m0_a_source,
  input  logic [31:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [1:0]  m1_a_size,
  input  logic        m1_a_source,
  input  logic [31:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [1:0]  m0_d_size,
  output logic        m0_d_source,
  output logic        m0_d_denied,
  output logic        m0_d_corrupt,
  output logic [31:0] m0_d_data,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [1:0]  m1_d_size,
  output logic        m1_d_source,
  output logic        m1_d_denied,
  output logic        m1_d_corrupt,
  output logic [31:0] m1_d_data,
  output logic        s_a_valid,
  input  logic        s_a_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [1:0]  s_a_size,
  output logic [1:0]  s_a_source,
  output logic [31:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [1:0]  s_d_size,
  input  logic [1:0]  s_d_source,
  input  logic        s_d_denied,
  input  logic        s_d_corrupt,
  input  logic [31:0] s_d_data,
  output logic        err_orphan,
  output logic        busy
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  // A response for a master with nothing outstanding must not wrap the count.
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic inc,
                                          input logic dec);
    logic dec_ok;
    dec_ok = dec & (cnt != 2'd0);
    case ({inc, dec_ok})
      2'b10:   cnt_step = cnt + 2'd1;
      2'b01:   cnt_step = cnt - 2'd1;
      default: cnt_step = cnt;
    endcase
  endfunction

  logic        rr;
  logic [1:0]  cnt_0, cnt_1;
  logic        elig_0, elig_1, win_1, room;
  logic        acc_0, acc_1, acc_any;
  logic        d_to_1, d_fire, dec_0, dec_1, orph_hit;
  logic [2:0]  sel_opcode, sel_param;
  logic [1:0]  sel_size;
  logic        sel_source;
  logic [31:0] sel_address, sel_data;
  logic [3:0]  sel_mask;

  logic        stg_vld_p1;
  logic [2:0]  stg_opcode_p1, stg_param_p1;
  logic [1:0]  stg_size_p1, stg_source_p1;
  logic [31:0] stg_address_p1, stg_data_p1;
  logic [3:0]  stg_mask_p1;

  always_comb begin
    elig_0  = m0_a_valid & (cnt_0 < MAX_CNT);
    elig_1  = m1_a_valid & (cnt_1 < MAX_CNT);
    win_1   = rr ? elig_1 : (elig_1 & ~elig_0);
    room    = ~stg_vld_p1 | s_a_ready;
    acc_0   = reset_n & elig_0 & ~win_1 & room;
    acc_1   = reset_n & win_1 & room;
    acc_any = acc_0 | acc_1;

    sel_opcode  = win_1 ? m1_a_opcode  : m0_a_opcode;
    sel_param   = win_1 ? m1_a_param   : m0_a_param;
    sel_size    = win_1 ? m1_a_size    : m0_a_size;
    sel_source  = win_1 ? m1_a_source  : m0_a_source;
    sel_address = win_1 ? m1_a_address : m0_a_address;
    sel_mask    = win_1 ? m1_a_mask    : m0_a_mask;
    sel_data    = win_1 ? m1_a_data    : m0_a_data;
  end

  assign m0_a_ready = acc_0;
  assign m1_a_ready = acc_1;

  // D channel: pure routing, outputs forced quiet while reset is held.
  assign d_to_1     = s_d_source[1];
  assign m0_d_valid = reset_n & s_d_valid & ~d_to_1;
  assign m1_d_valid = reset_n & s_d_valid & d_to_1;
  assign s_d_ready  = reset_n & (d_to_1 ? m1_d_ready : m0_d_ready);
  assign d_fire     = s_d_valid & s_d_ready;
  assign dec_0      = d_fire & ~d_to_1;
  assign dec_1      = d_fire & d_to_1;
  assign orph_hit   = (dec_0 & (cnt_0 == 2'd0)) | (dec_1 & (cnt_1 == 2'd0));

  assign m0_d_opcode  = s_d_opcode;
  assign m0_d_param   = s_d_param;
  assign m0_d_size    = s_d_size;
  assign m0_d_source  = s_d_source[0];
  assign m0_d_denied  = s_d_denied;
  assign m0_d_corrupt = s_d_corrupt;
  assign m0_d_data    = s_d_data;
  assign m1_d_opcode  = s_d_opcode;
  assign m1_d_param   = s_d_param;
  assign m1_d_size    = s_d_size;
  assign m1_d_source  = s_d_source[0];
  assign m1_d_denied  = s_d_denied;
  assign m1_d_corrupt = s_d_corrupt;
  assign m1_d_data    = s_d_data;

  // Stage p1: one-entry A register, refilled in the same cycle it drains.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr             <= 1'b0;
      cnt_0          <= 2'd0;
      cnt_1          <= 2'd0;
      err_orphan     <= 1'b0;
      stg_vld_p1     <= 1'b0;
      stg_opcode_p1  <= 3'd0;
      stg_param_p1   <= 3'd0;
      stg_size_p1    <= 2'd0;
      stg_source_p1  <= 2'd0;
      stg_address_p1 <= 32'd0;
      stg_mask_p1    <= 4'd0;
      stg_data_p1    <= 32'd0;
    end else begin
      cnt_0 <= cnt_step(cnt_0, acc_0, dec_0);
      cnt_1 <= cnt_step(cnt_1, acc_1, dec_1);
      if (orph_hit) err_orphan <= 1'b1;
      if (acc_any) begin
        rr             <= ~win_1;
        stg_vld_p1     <= 1'b1;
        stg_opcode_p1  <= sel_opcode;
        stg_param_p1   <= sel_param;
        stg_size_p1    <= sel_size;
        stg_source_p1  <= {win_1, sel_source};
        stg_address_p1 <= sel_address;
        stg_mask_p1    <= sel_mask;
        stg_data_p1    <= sel_data;
      end else if (s_a_ready) begin
        stg_vld_p1 <= 1'b0;
      end
    end
  end

  assign s_a_valid   = stg_vld_p1;
  assign s_a_opcode  = stg_opcode_p1;
  assign s_a_param   = stg_param_p1;
  assign s_a_size    = stg_size_p1;
  assign s_a_source  = stg_source_p1;
  assign s_a_address = stg_address_p1;
  assign s_a_mask    = stg_mask_p1;
  assign s_a_data    = stg_data_p1;

  assign busy = stg_vld_p1 | (cnt_0 != 2'd0) | (cnt_1 != 2'd0);

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: directed scenarios plus random traffic against a
// transaction-level model (outstanding counts, expected-beat queue, orphan flag).
module tb_tl_ul_arb2;
  localparam int MAX = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [1:0]  size;
    logic [1:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
  } beat_t;

  logic clock, reset_n;
  logic        a_valid [2];
  logic [2:0]  a_opcode [2];
  logic [2:0]  a_param [2];
  logic [1:0]  a_size [2];
  logic        a_source [2];
  logic [31:0] a_address [2];
  logic [3:0]  a_mask [2];
  logic [31:0] a_data [2];
  logic        d_ready [2];
  logic        s_a_ready, s_d_valid, s_d_denied, s_d_corrupt;
  logic [2:0]  s_d_opcode;
  logic [1:0]  s_d_param, s_d_size, s_d_source;
  logic [31:0] s_d_data;

  logic        m0_a_ready, m1_a_ready, m0_d_valid, m1_d_valid;
  logic [2:0]  m0_d_opcode, m1_d_opcode;
  logic [1:0]  m0_d_param, m1_d_param, m0_d_size, m1_d_size;
  logic        m0_d_source, m1_d_source, m0_d_denied, m1_d_denied;
  logic        m0_d_corrupt, m1_d_corrupt;
  logic [31:0] m0_d_data, m1_d_data;
  logic        s_a_valid, s_d_ready, err_orphan, busy;
  logic [2:0]  s_a_opcode, s_a_param;
  logic [1:0]  s_a_size, s_a_source;
  logic [31:0] s_a_address, s_a_data;
  logic [3:0]  s_a_mask;

  tl_ul_arb2 #(.MAX_OUTSTANDING(MAX)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_a_valid(a_valid[0]), .m0_a_ready(m0_a_ready), .m0_a_opcode(a_opcode[0]),
    .m0_a_param(a_param[0]), .m0_a_size(a_size[0]), .m0_a_source(a_source[0]),
    .m0_a_address(a_address[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
    .m1_a_valid(a_valid[1]), .m1_a_ready(m1_a_ready), .m1_a_opcode(a_opcode[1]),
    .m1_a_param(a_param[1]), .m1_a_size(a_size[1]), .m1_a_source(a_source[1]),
    .m1_a_address(a_address[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
    .m0_d_valid(m0_d_valid), .m0_d_ready(d_ready[0]), .m0_d_opcode(m0_d_opcode),
    .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
    .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt), .m0_d_data(m0_d_data),
    .m1_d_valid(m1_d_valid), .m1_d_ready(d_ready[1]), .m1_d_opcode(m1_d_opcode),
    .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
    .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt), .m1_d_data(m1_d_data),
    .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
    .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
    .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
    .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
    .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt), .s_d_data(s_d_data),
    .err_orphan(err_orphan), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    outst [2];
  int    rr_m;
  bit    orph;
  beat_t stage_q [$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    for (int x = 0; x < 2; x++) begin
      a_opcode[x]  = 3'($urandom);
      a_param[x]   = 3'($urandom);
      a_size[x]    = 2'($urandom);
      a_source[x]  = 1'($urandom);
      a_address[x] = $urandom;
      a_mask[x]    = 4'($urandom);
      a_data[x]    = $urandom;
    end
    s_d_opcode  = 3'($urandom);
    s_d_param   = 2'($urandom);
    s_d_size    = 2'($urandom);
    s_d_denied  = 1'($urandom);
    s_d_corrupt = 1'($urandom);
    s_d_data    = $urandom;
  endtask

  task automatic idle_inputs();
    rand_fields();
    a_valid[0] = 1'b0; a_valid[1] = 1'b0;
    d_ready[0] = 1'b0; d_ready[1] = 1'b0;
    s_a_ready  = 1'b0; s_d_valid  = 1'b0; s_d_source = 2'b00;
  endtask

  task automatic model_clear();
    outst[0] = 0; outst[1] = 0; rr_m = 0; orph = 1'b0;
    stage_q.delete();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Compare every output against the model for the current inputs, then advance one clock.
  task automatic cycle();
    bit    el [2];
    int    w, dx;
    bit    room, fire;
    beat_t b;
    #3;
    for (int x = 0; x < 2; x++) el[x] = a_valid[x] && (outst[x] < MAX);
    w = -1;
    if (el[rr_m]) w = rr_m;
    else if (el[1 - rr_m]) w = 1 - rr_m;
    room = (stage_q.size() == 0) || s_a_ready;
    chk("m0_a_ready", 128'(m0_a_ready), 128'(w == 0 && room));
    chk("m1_a_ready", 128'(m1_a_ready), 128'(w == 1 && room));
    chk("s_a_valid", 128'(s_a_valid), 128'(stage_q.size() != 0));
    if (stage_q.size() != 0)
      chk("s_a_beat", 128'({s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address,
                            s_a_mask, s_a_data}), 128'(stage_q[0]));
    dx = int'(s_d_source[1]);
    chk("m0_d_valid", 128'(m0_d_valid), 128'(s_d_valid && dx == 0));
    chk("m1_d_valid", 128'(m1_d_valid), 128'(s_d_valid && dx == 1));
    chk("s_d_ready", 128'(s_d_ready), 128'(d_ready[dx]));
    chk("m0_d_fields", 128'({m0_d_opcode, m0_d_param, m0_d_size, m0_d_source, m0_d_denied,
                             m0_d_corrupt, m0_d_data}),
        128'({s_d_opcode, s_d_param, s_d_size, s_d_source[0], s_d_denied, s_d_corrupt, s_d_data}));
    chk("m1_d_fields", 128'({m1_d_opcode, m1_d_param, m1_d_size, m1_d_source, m1_d_denied,
                             m1_d_corrupt, m1_d_data}),
        128'({s_d_opcode, s_d_param, s_d_size, s_d_source[0], s_d_denied, s_d_corrupt, s_d_data}));
    chk("busy", 128'(busy), 128'(stage_q.size() != 0 || outst[0] != 0 || outst[1] != 0));
    chk("err_orphan", 128'(err_orphan), 128'(orph));
    fire = s_d_valid && d_ready[dx];
    if (fire) begin
      if (outst[dx] == 0) orph = 1'b1;
      else outst[dx]--;
    end
    if (stage_q.size() != 0 && s_a_ready) stage_q.delete(0);
    if (w >= 0 && room) begin
      b.opcode  = a_opcode[w];
      b.param   = a_param[w];
      b.size    = a_size[w];
      b.source  = {w[0], a_source[w]};
      b.address = a_address[w];
      b.mask    = a_mask[w];
      b.data    = a_data[w];
      stage_q.push_back(b);
      outst[w]++;
      rr_m = 1 - w;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int dx;
    idle_inputs();
    model_clear();
    reset_n = 1'b0;
    a_valid[0] = 1'b1; a_valid[1] = 1'b1; s_a_ready = 1'b1;
    #3;
    chk("rst_m0_a_ready", 128'(m0_a_ready), 128'(0));
    chk("rst_m1_a_ready", 128'(m1_a_ready), 128'(0));
    chk("rst_s_a_valid", 128'(s_a_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err_orphan", 128'(err_orphan), 128'(0));
    chk("rst_s_a_data", 128'({s_a_address, s_a_data}), 128'(0));

    // Alternating grants under continuous requests with immediate responses.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      a_source[0] = 1'b0; a_source[1] = 1'b0;
      a_valid[0] = 1'b1; a_valid[1] = 1'b1; s_a_ready = 1'b1;
      d_ready[0] = 1'b1; d_ready[1] = 1'b1;
      s_d_valid  = (outst[0] > 0) || (outst[1] > 0);
      s_d_source = {(outst[0] > 0) ? 1'b0 : 1'b1, 1'($urandom)};
      #1;
      chk("alt_grant", 128'({m1_a_ready, m0_a_ready}), 128'((k % 2 == 0) ? 2'b01 : 2'b10));
      cycle();
      chk("alt_source", 128'(s_a_source), 128'((k % 2 == 0) ? 2'b00 : 2'b10));
    end

    // Outstanding limit on m0; m1 still served; one response reopens m0.
    do_reset();
    rand_fields();
    a_opcode[0] = 3'd4; a_valid[0] = 1'b1; s_a_ready = 1'b1;
    cycle();
    cycle();
    a_valid[1] = 1'b1;
    #1;
    chk("m0_limit", 128'(m0_a_ready), 128'(0));
    chk("m1_while_m0_full", 128'(m1_a_ready), 128'(1));
    cycle();
    a_valid[1] = 1'b0; s_d_valid = 1'b1; s_d_source = 2'b01; d_ready[0] = 1'b1;
    #1;
    chk("m0_still_full", 128'(m0_a_ready), 128'(0));
    cycle();
    s_d_valid = 1'b0;
    #1;
    chk("m0_after_d", 128'(m0_a_ready), 128'(1));
    cycle();

    // Stage holds under back-pressure, no grants while full.
    do_reset();
    rand_fields();
    a_valid[1] = 1'b1; a_address[1] = 32'h8000_0010; a_source[1] = 1'b1;
    cycle();
    for (int k = 0; k < 5; k++) begin
      rand_fields();
      a_valid[0] = 1'b1; a_valid[1] = 1'b1; s_a_ready = 1'b0;
      #1;
      chk("hold_addr", 128'(s_a_address), 128'(32'h8000_0010));
      chk("hold_src", 128'(s_a_source), 128'(2'b11));
      chk("hold_no_grant", 128'({m1_a_ready, m0_a_ready}), 128'(2'b00));
      cycle();
    end
    a_valid[0] = 1'b0; a_valid[1] = 1'b0; s_a_ready = 1'b1;
    cycle();

    // D back-pressure from m1, then completion drops the count.
    s_d_valid = 1'b1; s_d_source = 2'b11; d_ready[0] = 1'b1; d_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("d_bp_s_d_ready", 128'(s_d_ready), 128'(0));
      chk("d_bp_m0_d_valid", 128'(m0_d_valid), 128'(0));
      chk("d_bp_m1_d_valid", 128'(m1_d_valid), 128'(1));
      cycle();
    end
    d_ready[1] = 1'b1;
    #1;
    chk("d_release", 128'(s_d_ready), 128'(1));
    cycle();
    s_d_valid = 1'b0;
    #1;
    chk("cnt1_dec", 128'(busy), 128'(0));
    cycle();

    // Orphan response: sticky flag, count stays at zero.
    do_reset();
    s_d_valid = 1'b1; s_d_source = 2'b00; d_ready[0] = 1'b1;
    cycle();
    s_d_valid = 1'b0;
    #1;
    chk("orphan_set", 128'(err_orphan), 128'(1));
    chk("orphan_busy", 128'(busy), 128'(0));
    repeat (3) cycle();
    a_valid[0] = 1'b1; s_a_ready = 1'b1;
    cycle();
    a_valid[0] = 1'b0;
    cycle();
    s_d_valid = 1'b1; s_d_source = 2'b00;
    cycle();
    s_d_valid = 1'b0;
    #1;
    chk("orphan_sticky", 128'(err_orphan), 128'(1));
    chk("no_underflow", 128'(busy), 128'(0));
    cycle();

    // Asynchronous reset with a staged beat and two m1 requests outstanding.
    do_reset();
    a_valid[1] = 1'b1; s_a_ready = 1'b1;
    cycle();
    cycle();
    s_a_ready = 1'b0; a_valid[0] = 1'b1; a_valid[1] = 1'b1;
    s_d_valid = 1'b1; s_d_source = 2'b11; d_ready[1] = 1'b1;
    #1;
    chk("pre_rst_busy", 128'(busy), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("async_s_a_valid", 128'(s_a_valid), 128'(0));
    chk("async_busy", 128'(busy), 128'(0));
    chk("async_a_ready", 128'({m1_a_ready, m0_a_ready}), 128'(2'b00));
    chk("async_m1_d_valid", 128'(m1_d_valid), 128'(0));
    chk("async_stage_zero", 128'({s_a_source, s_a_address}), 128'(0));
    model_clear();
    idle_inputs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    a_valid[0] = 1'b1; a_valid[1] = 1'b1; s_a_ready = 1'b1;
    #1;
    chk("rr_after_reset", 128'({m1_a_ready, m0_a_ready}), 128'(2'b01));
    cycle();
    chk("first_grant_edge", 128'(s_a_valid), 128'(1));

    // Random traffic; responses only target masters with something outstanding.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_fields();
      a_valid[0] = ($urandom_range(0, 3) != 0);
      a_valid[1] = ($urandom_range(0, 3) != 0);
      s_a_ready  = ($urandom_range(0, 3) != 0);
      d_ready[0] = ($urandom_range(0, 3) != 0);
      d_ready[1] = ($urandom_range(0, 3) != 0);
      dx = int'($urandom_range(0, 1));
      s_d_valid  = (outst[dx] > 0) && ($urandom_range(0, 1) != 0);
      s_d_source = {dx[0], 1'($urandom)};
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
